serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 22 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state encoding,
// default operand width and signed saturation limits.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Limits are built at 64 bits and truncated to the operand width by the caller.
  function automatic logic [63:0] signed_min(input int unsigned w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic logic [63:0] signed_max(input int unsigned w);
    return signed_min(w) - 64'(1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor cell (X - Y - B_in), gate-style like
// the companion adder cell.
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic B_in,
  output logic Dif,
  output logic B_out
);

  logic xy_x;
  logic nx_and_y;
  logic eq_and_bin;

  assign xy_x       = X ^ Y;
  assign Dif        = xy_x ^ B_in;
  assign nx_and_y   = ~X & Y;
  assign eq_and_bin = ~xy_x & B_in;
  assign B_out      = nx_and_y | eq_and_bin;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B, LSB first, one bit per cycle,
// with valid/ready handshakes. Define SERIAL_SUB_SAT_EN to saturate D on overflow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BORROW,
  output logic             OVF
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bin_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             ovf_q;

  logic             diff;
  logic             bout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;
  logic             ovf_calc;

`ifdef SERIAL_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(signed_max(WIDTH));
`endif

  full_subtractor u_cell (
    .X    (a_q[0]),
    .Y    (b_q[0]),
    .B_in (bin_q),
    .Dif  (diff),
    .B_out(bout)
  );

  assign accept    = (state == IDLE) && in_valid;
  assign last_bit  = (state == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  // The bit computed this cycle becomes the MSB of the result on the final shift,
  // so overflow is judged against diff rather than the not-yet-updated register.
  assign res_shift = {diff, res_q[WIDTH-1:1]};
  assign ovf_calc  = (sign_a_q != sign_b_q) && (diff != sign_a_q);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      sign_a_q <= A[WIDTH-1];
      sign_b_q <= B[WIDTH-1];
    end else if (state == SHIFT) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      bin_q <= bout;
      cnt_q <= cnt_q + CNT_W'(1);
      res_q <= res_shift;
      if (last_bit) begin
        ovf_q <= ovf_calc;
`ifdef SERIAL_SUB_SAT_EN
        if (ovf_calc) begin
          res_q <= sign_a_q ? SAT_MIN : SAT_MAX;
        end
`endif
      end
    end
  end

  // Nothing above updates in DONE, so the outputs stay frozen while stalled.
  assign D      = res_q;
  assign BORROW = bin_q;
  assign OVF    = ovf_q;

endmodule
